// File: rtl/matrix_addsub_stream.sv
// matrix_addsub_stream
//   Element-wise signed matrix add/subtract engine. A command (start) latches
//   the operation and overflow mode, then N_ROWS packed row pairs are accepted
//   over a valid/ready interface. Each result row appears one cycle after it is
//   accepted, held in a single-entry output register.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start, op_sub, sat_en command strobe (IDLE only), 0=add/1=sub, 0=wrap/1=saturate
//   in_valid, in_ready   row-pair handshake
//   m1, m2               packed operand rows, lane i = [i*ELEM_W +: ELEM_W]
//   out_valid, out_ready result handshake
//   m_out, ovf_lanes     result row and its per-lane overflow flags
//   busy                 command in progress (RUN or DRAIN)
//   done                 pulse on handshake of the final result row
//   ovf                  sticky overflow of the current/last matrix
module matrix_addsub_stream #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 5,
    parameter int N_ROWS = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     op_sub,
    input  logic                     sat_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_ELEM*ELEM_W-1:0] m1,
    input  logic [N_ELEM*ELEM_W-1:0] m2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_ELEM*ELEM_W-1:0] m_out,
    output logic [N_ELEM-1:0]        ovf_lanes,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf
);

    localparam int RW = N_ELEM * ELEM_W;
    localparam int CW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       row_cnt;
    logic                op_q, sat_q;
    logic                in_hs, out_hs, last_row;
    logic [RW-1:0]       res;
    logic [N_ELEM-1:0]   res_ovf;
    logic signed [ELEM_W:0] a_ext, b_ext, sum;

    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;
    assign last_row = (row_cnt == CW'(N_ROWS - 1));

    // Per-lane arithmetic at ELEM_W+1 bits: the result overflows the element
    // range exactly when its top two bits disagree, and the top bit then gives
    // the direction of the overflow.
    always_comb begin
        res     = '0;
        res_ovf = '0;
        a_ext   = '0;
        b_ext   = '0;
        sum     = '0;
        for (int unsigned i = 0; i < N_ELEM; i++) begin
            a_ext = {m1[i*ELEM_W + ELEM_W - 1], m1[i*ELEM_W +: ELEM_W]};
            b_ext = {m2[i*ELEM_W + ELEM_W - 1], m2[i*ELEM_W +: ELEM_W]};
            sum   = op_q ? (a_ext - b_ext) : (a_ext + b_ext);
            res_ovf[i] = sum[ELEM_W] ^ sum[ELEM_W-1];
            if (res_ovf[i] && sat_q) begin
                res[i*ELEM_W +: ELEM_W] = sum[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}}
                                                      : {1'b0, {(ELEM_W-1){1'b1}}};
            end else begin
                res[i*ELEM_W +: ELEM_W] = sum[ELEM_W-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                // Accept a new row whenever the output register is free or
                // being emptied this cycle, so a full-rate stream has no bubble.
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready && last_row) state_nx = DRAIN;
            end
            DRAIN: begin
                if (out_hs) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            op_q      <= 1'b0;
            sat_q     <= 1'b0;
            out_valid <= 1'b0;
            m_out     <= '0;
            ovf_lanes <= '0;
            ovf       <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                op_q    <= op_sub;
                sat_q   <= sat_en;
                row_cnt <= '0;
                ovf     <= 1'b0;
            end
            if (in_hs) begin
                m_out     <= res;
                ovf_lanes <= res_ovf;
                out_valid <= 1'b1;
                ovf       <= ovf | (|res_ovf);
                if (!last_row) row_cnt <= row_cnt + 1'b1;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_addsub_stream.sv
// Directed bench for matrix_addsub_stream: a 5-row instance for streaming,
// backpressure, sticky overflow, reset abort and start-while-busy, plus a
// 1-row instance for single-row arithmetic vectors.
module tb_matrix_addsub_stream;

    logic        clk = 1'b0;
    logic        rst, op_sub, sat_en, out_ready;
    logic [39:0] m1, m2;

    logic        start, in_valid, in_ready, out_valid, busy, done, ovf;
    logic [39:0] m_out;
    logic [4:0]  ovf_lanes;

    logic        start1, in_valid1, in_ready1, out_valid1, busy1, done1, ovf1;
    logic [39:0] m_out1;
    logic [4:0]  ovf_lanes1;

    int          total = 0;
    int          bad   = 0;
    int          nin, nout, cyc;
    logic        hs_in, hs_out, stalled;
    logic [39:0] held;

    logic [39:0] ra[5], rb[5], rexp[5];
    logic [4:0]  rovl[5];
    logic        rovf[5];

    always #5 clk = ~clk;

    matrix_addsub_stream #(.ELEM_W(8), .N_ELEM(5), .N_ROWS(5)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .sat_en(sat_en),
        .in_valid(in_valid), .in_ready(in_ready), .m1(m1), .m2(m2),
        .out_valid(out_valid), .out_ready(out_ready), .m_out(m_out),
        .ovf_lanes(ovf_lanes), .busy(busy), .done(done), .ovf(ovf)
    );

    matrix_addsub_stream #(.ELEM_W(8), .N_ELEM(5), .N_ROWS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_sub(op_sub), .sat_en(sat_en),
        .in_valid(in_valid1), .in_ready(in_ready1), .m1(m1), .m2(m2),
        .out_valid(out_valid1), .out_ready(out_ready), .m_out(m_out1),
        .ovf_lanes(ovf_lanes1), .busy(busy1), .done(done1), .ovf(ovf1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Lanes listed lane4..lane0; lane0 lands at the LSB.
    function automatic logic [39:0] pk(input int l4, input int l3, input int l2,
                                       input int l1, input int l0);
        return {l4[7:0], l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    task automatic run1(input string tag, input logic o, input logic s,
                        input logic [39:0] a, input logic [39:0] b,
                        input logic [39:0] em, input logic [4:0] el, input logic ev);
        op_sub = o; sat_en = s; start1 = 1'b1;
        tick();
        start1 = 1'b0; op_sub = ~o; sat_en = ~s;
        chk({tag, "_busy"}, 64'(busy1), 64'd1);
        chk({tag, "_inrdy"}, 64'(in_ready1), 64'd1);
        m1 = a; m2 = b; in_valid1 = 1'b1; out_ready = 1'b1;
        tick();
        in_valid1 = 1'b0;
        chk({tag, "_ovalid"}, 64'(out_valid1), 64'd1);
        chk({tag, "_mout"}, 64'(m_out1), 64'(em));
        chk({tag, "_ovfl"}, 64'(ovf_lanes1), 64'(el));
        chk({tag, "_ovf"}, 64'(ovf1), 64'(ev));
        chk({tag, "_done"}, 64'(done1), 64'd1);
        tick();
        chk({tag, "_idle"}, 64'(busy1), 64'd0);
        chk({tag, "_done_off"}, 64'(done1), 64'd0);
        chk({tag, "_ovalid_off"}, 64'(out_valid1), 64'd0);
    endtask

    task automatic stream_full(input string tag, input logic o, input logic s,
                               input logic poke_start);
        op_sub = o; sat_en = s; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        for (int r = 0; r < 5; r++) begin
            m1 = ra[r]; m2 = rb[r]; in_valid = 1'b1; out_ready = 1'b1;
            if (poke_start) begin
                start = 1'b1; op_sub = ~o; sat_en = ~s;
            end
            #1;
            chk($sformatf("%s_inrdy%0d", tag, r), 64'(in_ready), 64'd1);
            tick();
            start = 1'b0;
            chk($sformatf("%s_ovalid%0d", tag, r), 64'(out_valid), 64'd1);
            chk($sformatf("%s_mout%0d", tag, r), 64'(m_out), 64'(rexp[r]));
            chk($sformatf("%s_ovfl%0d", tag, r), 64'(ovf_lanes), 64'(rovl[r]));
            chk($sformatf("%s_ovf%0d", tag, r), 64'(ovf), 64'(rovf[r]));
            chk($sformatf("%s_done%0d", tag, r), 64'(done), 64'(r == 4));
        end
        in_valid = 1'b0;
        tick();
        chk({tag, "_end_busy"}, 64'(busy), 64'd0);
        chk({tag, "_end_ovalid"}, 64'(out_valid), 64'd0);
        chk({tag, "_end_done"}, 64'(done), 64'd0);
    endtask

    task automatic set_add();
        for (int r = 0; r < 5; r++) begin
            ra[r]   = pk(10*r+4, 10*r+3, 10*r+2, 10*r+1, 10*r);
            rb[r]   = pk(4, 3, 2, 1, 0);
            rexp[r] = pk(10*r+8, 10*r+6, 10*r+4, 10*r+2, 10*r);
            rovl[r] = 5'b0;
            rovf[r] = 1'b0;
        end
    endtask

    // Subtract rows that stay in range, except row 2 which overflows in lanes 3 and 0.
    task automatic set_sub_ovf();
        for (int r = 0; r < 5; r++) begin
            ra[r]   = pk(10*r+24, 10*r+23, 10*r+22, 10*r+21, 10*r+20);
            rb[r]   = pk(4, 3, 2, 1, 0);
            rexp[r] = pk(10*r+20, 10*r+20, 10*r+20, 10*r+20, 10*r+20);
            rovl[r] = 5'b0;
            rovf[r] = (r >= 2);
        end
        ra[2]   = pk(100, -100, 127, -128, 50);
        rb[2]   = pk(30, 30, 1, -1, -100);
        rexp[2] = pk(70, 126, 126, -127, -106);
        rovl[2] = 5'b01001;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0; op_sub = 1'b0; sat_en = 1'b0;
        in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0; m1 = '0; m2 = '0;
        tick(); tick();
        chk("rst_inrdy", 64'(in_ready), 64'd0);
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        chk("rst_mout", 64'(m_out), 64'd0);
        chk("rst_ovfl", 64'(ovf_lanes), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        tick();

        // Single-row arithmetic vectors on the N_ROWS=1 instance.
        run1("add1", 1'b0, 1'b0, pk(10, 20, 30, 40, 50), pk(5, 15, 25, 35, 45),
             pk(15, 35, 55, 75, 95), 5'b00000, 1'b0);
        run1("subwrap", 1'b1, 1'b0, pk(100, -100, 127, -128, 50), pk(30, 30, 1, -1, -100),
             pk(70, 126, 126, -127, -106), 5'b01001, 1'b1);
        run1("subsat", 1'b1, 1'b1, pk(100, -100, 127, -128, 50), pk(30, 30, 1, -1, -100),
             pk(70, -128, 126, -127, 127), 5'b01001, 1'b1);

        // Full-rate stream.
        set_add();
        stream_full("full", 1'b0, 1'b0, 1'b0);

        // Backpressure with out_ready toggling 1010...
        op_sub = 1'b0; sat_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        nin = 0; nout = 0; cyc = 0; stalled = 1'b0;
        while (nout < 5 && cyc < 60) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = (nin < 5);
            if (nin < 5) begin
                m1 = ra[nin]; m2 = rb[nin];
            end
            #1;
            if (out_valid && !out_ready)
                chk($sformatf("bp_inrdy_c%0d", cyc), 64'(in_ready), 64'd0);
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            if (hs_out) begin
                chk($sformatf("bp_mout%0d", nout), 64'(m_out), 64'(rexp[nout]));
                chk($sformatf("bp_done%0d", nout), 64'(done), 64'(nout == 4));
                nout++;
            end
            if (out_valid && !out_ready) begin
                held = m_out; stalled = 1'b1;
            end
            tick();
            cyc++;
            if (stalled) begin
                chk($sformatf("bp_hold_c%0d", cyc), 64'(m_out), 64'(held));
                stalled = 1'b0;
            end
            if (hs_in) nin++;
        end
        chk("bp_rows_out", 64'(nout), 64'd5);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_end_busy", 64'(busy), 64'd0);

        // Sticky overflow from row 2 only, held in IDLE, cleared by a new start.
        set_sub_ovf();
        stream_full("ovf", 1'b1, 1'b0, 1'b0);
        tick(); tick();
        chk("ovf_idle_hold", 64'(ovf), 64'd1);
        op_sub = 1'b1; sat_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovf_cleared", 64'(ovf), 64'd0);

        // Reset abort after row 2 is accepted.
        for (int r = 0; r < 3; r++) begin
            m1 = ra[r]; m2 = rb[r]; in_valid = 1'b1; out_ready = 1'b1;
            tick();
            chk($sformatf("abort_mout%0d", r), 64'(m_out), 64'(rexp[r]));
        end
        chk("abort_ovf_pre", 64'(ovf), 64'd1);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ovalid", 64'(out_valid), 64'd0);
        chk("abort_mout", 64'(m_out), 64'd0);
        chk("abort_ovfl", 64'(ovf_lanes), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        chk("abort_inrdy", 64'(in_ready), 64'd0);
        tick();
        chk("abort_still_idle", 64'(busy), 64'd0);

        // start (with flipped op) held high during RUN must not disturb the command.
        set_add();
        stream_full("busystart", 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_addsub_stream.md
# matrix_addsub_stream

Parametrised element-wise matrix add/subtract engine for the matrix coprocessor datapath; successor to the fixed 5-lane, 8-bit, subtract-only unit. It accepts one full matrix operation (command), streams N_ROWS packed row pairs through a valid/ready interface, and emits each result row one cycle later. Lanes are signed. Per-lane overflow is reported per row and accumulated as a sticky per-matrix flag. Overflowing lanes either wrap or saturate, selectable per command.

## Interface

- ELEM_W, 8, signed element width in bits (≥2)
- N_ELEM, 5, elements (lanes) per packed row
- N_ROWS, 5, rows per matrix operation (≥1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe, accepted only in IDLE
- op_sub  in  1  command op: 0 = m1+m2, 1 = m1−m2 (latched on start)
- sat_en  in  1  command mode: 0 = wrap, 1 = saturate (latched on start)
- in_valid  in  1  row pair valid
- in_ready  out  1  row pair accepted when in_valid & in_ready
- m1, m2  in  N_ELEM*ELEM_W  packed operand rows; lane i = bits [i*ELEM_W +: ELEM_W], lane 0 at LSB
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- m_out  out  N_ELEM*ELEM_W  packed result row, same lane layout
- ovf_lanes  out  N_ELEM  per-lane overflow of the row on m_out
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse on handshake of final result row
- ovf  out  1  sticky: any lane of any row of the current/last matrix overflowed

## Operation

- States: IDLE, RUN, DRAIN.
- IDLE: in_ready=0. start=1 → latch op_sub/sat_en, clear row counter and ovf, go RUN. Other inputs ignored.
- RUN: in_ready = !out_valid | out_ready (single-entry output register, no bubble at full rate). On input handshake: compute row, load output register, set out_valid, increment row counter. Handshake on row N_ROWS−1 → DRAIN.
- DRAIN: in_ready=0. On output handshake of final row → done=1 for that cycle, out_valid cleared, go IDLE.
- start while busy is ignored; command latches unchanged.
- Arithmetic per lane: extend operands to ELEM_W+1 signed, add or subtract. Overflow when the result lies outside [−2^(ELEM_W−1), 2^(ELEM_W−1)−1].
- Wrap mode: m_out lane = low ELEM_W bits. Saturate mode: clamp to max on positive overflow and min on negative overflow.
- ovf_lanes is registered with m_out. ovf |= OR(ovf_lanes) on each input handshake. ovf holds after done until the next accepted start.
- Row counter width is clog2(N_ROWS), minimum 1. It never wraps within a command.

## Timing

- Reset values: in_ready=0, out_valid=0, m_out=0, ovf_lanes=0, busy=0, done=0, ovf=0, state=IDLE.
- rst mid-operation aborts the command: everything returns to reset values next cycle, no done pulse, and partially emitted rows are discarded.
- start accepted in cycle t → busy=1 and in_ready=1 in cycle t+1.
- Latency: row accepted at edge t → m_out/out_valid valid after edge t, i.e. one cycle.
- Throughput: one row per cycle while out_ready=1. Backpressure (out_ready=0 with out_valid=1) forces in_ready=0 and holds m_out and ovf_lanes stable.
- Simultaneous output handshake and input handshake in the same cycle: the register takes the new row and out_valid stays 1.
- done is asserted in the same cycle as the final output handshake, and busy drops the following cycle.
- Minimum command duration is N_ROWS+1 cycles after start acceptance.

## Test plan

- Add, wrap, N_ROWS=1, rows listed lane4..lane0: m1=[10,20,30,40,50], m2=[5,15,25,35,45] → m_out=[15,35,55,75,95], ovf_lanes=0, ovf=0, done one cycle after input handshake.
- Sub, wrap: m1=[100,−100,127,−128,50], m2=[30,30,1,−1,−100] → m_out=[70,126,126,−127,−106], ovf_lanes=5'b01001, ovf=1.
- Same vectors, sat_en=1 → m_out=[70,−128,126,−127,127], ovf_lanes=5'b01001.
- N_ROWS=5 streamed with out_ready=1 every cycle → 5 consecutive out_valid cycles, done on the 5th, no bubbles. Repeat with out_ready toggled 1010… → m_out is held while stalled, row order is preserved, and the total count is 5.
- Overflow on row 2 only, rows 3–4 clean → ovf=1 at done and held in IDLE. A new start → ovf=0.
- rst asserted after row 2 accepted → all outputs are 0 next cycle and no done. start during RUN is ignored: the command completes with its original op.
